seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the 8-bit combinational ALU.
- Adds registered results, a 4-bit opcode space, an iterative multiplier/divider and status flags.
- Sits between decode/register-read and writeback; the stall logic back-pressures via `in_ready`.

Parameters:
- `WIDTH`, 8, operand/result width in bits (>=4).
- `CNT_W`, `$clog2(WIDTH)+1`, width of the iteration counter.

Ports:
- `clk`, input, 1, clock; all state on rising edge.
- `reset_n`, input, 1, asynchronous active-low reset.
- `in_valid`, input, 1, operands/opcode valid.
- `in_ready`, output, 1, block can accept an operation.
- `alu_input_a`, input, WIDTH, first operand.
- `alu_input_b`, input, WIDTH, second operand.
- `alu_opcode`, input, 4, operation code.
- `out_valid`, output, 1, result valid.
- `out_ready`, input, 1, consumer accepts result.
- `alu_out`, output, WIDTH, result.
- `zero`, output, 1, `alu_out == 0`.
- `carry`, output, 1, carry/borrow out of ADD/SUB/OVF; 0 otherwise.
- `div_zero`, output, 1, DIVU/REMU issued with b == 0.

Behaviour:
- Reset (async, any state including mid-iteration): state=IDLE, `in_ready`=1, `out_valid`=0, `alu_out`=0, `zero`=1, `carry`=0, `div_zero`=0, counter=0. Any in-flight operation is discarded.
- Opcodes:
  - 0 AND; 1 ADD (mod 2^WIDTH); 2 XOR; 3 SLTU (unsigned, result 1/0).
  - 4 SLL; 5 SRL; 6 SNE (result 1/0); 7 OVF (result 1 if a+b >= 2^WIDTH).
  - 8 SUB (a-b mod 2^WIDTH, `carry`=borrow); 9 OR; 10 SRA.
  - 11 MUL (low WIDTH bits); 12 DIVU; 13 REMU; 14 MULHU (high WIDTH bits); 15 PASSB.
- Shifts use the full b value. b >= WIDTH: SLL/SRL give 0, SRA gives WIDTH copies of a[WIDTH-1].
- States and transitions:
  - IDLE -> DONE on handshake for opcodes other than 11-14.
  - IDLE -> EXEC on handshake for opcodes 11-14.
  - EXEC -> DONE when counter reaches WIDTH.
  - DONE -> IDLE when `out_ready`.
- Handshake:
  - Accept when `in_valid && in_ready`.
  - `in_ready` = (state==IDLE).
  - Operands and opcode are latched at accept; inputs are ignored afterwards.
- Latency, accept at edge N:
  - Single-cycle ops: `out_valid`=1 after edge N+1.
  - MUL/MULHU: shift-add, one multiplier bit per cycle, WIDTH cycles; `out_valid` after edge N+1+WIDTH.
  - DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH cycles; same latency as MUL.
- Output hold:
  - `alu_out`/flags are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` drops the cycle after the `out_valid && out_ready` edge.
  - No new accept occurs in the same cycle as result retirement; one bubble is required.
- Divide by zero: quotient = all ones, remainder = a, `div_zero`=1, latency is unchanged.
- Flags:
  - `zero` is registered with `alu_out`.
  - `carry` = bit WIDTH of a+b for ADD/OVF; borrow for SUB (a<b).
  - `div_zero` is 0 for non-divide ops.
- Internal product register is 2*WIDTH bits; no intermediate truncation.

Optional Feature:
- Macro: `SEQ_ALU_EARLY_TERM_EN`.
- Defined: MUL/MULHU leave EXEC as soon as all remaining unprocessed multiplier bits are 0. The result is identical.
  - Latency = 1 + (index of highest set bit of b) + 1 cycles.
  - b==0 gives 1 EXEC cycle.
  - Divide latency is unchanged.
- Undefined: fixed WIDTH-cycle multiply as above.

Test Plan:
- WIDTH=8: reset low mid-EXEC of MUL -> same cycle `out_valid`=0, `in_ready`=1, `alu_out`=0, `zero`=1; after release, ADD 3+4 -> `alu_out`=7 one cycle after accept.
- ADD 0xFF+0x01 -> `alu_out`=0x00, `zero`=1, `carry`=1. OVF with the same operands -> `alu_out`=1. SUB 0x02-0x05 -> `alu_out`=0xFD, `carry`=1.
- MUL 0x13*0x0B -> `alu_out`=0xD1. MULHU 0xFF*0xFF -> `alu_out`=0xFE. Both valid exactly 9 cycles after accept without the macro; `in_ready`=0 throughout.
- DIVU 200/7 -> 28; REMU 200/7 -> 4; DIVU 9/0 -> 0xFF with `div_zero`=1; REMU 9/0 -> 9.
- SLL 0x81 by 1 -> 0x02; SRL by 8 -> 0x00; SRA 0x80 by 9 -> 0xFF. Hold `out_ready`=0 for 5 cycles -> output stable, no new accept.
- With `SEQ_ALU_EARLY_TERM_EN`: MUL 0x55*0x03 -> 0xFF, valid 3 cycles after accept. MUL 0x55*0x00 -> 0x00, `zero`=1, valid 2 cycles after accept.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked sequential ALU with registered result/flags, shift-add multiplier
// and restoring divider. Optional macro SEQ_ALU_EARLY_TERM_EN ends multiplies early.
module seq_alu #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_input_a,
   input  logic [WIDTH-1:0] alu_input_b,
   input  logic [3:0]       alu_opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic             carry,
   output logic             div_zero
);
   localparam int unsigned      SH_W     = $clog2(WIDTH);
   localparam int unsigned      PW       = 2 * WIDTH;
   localparam logic [WIDTH-1:0] W_LIM    = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_SLTU  = 4'd3;
   localparam logic [3:0] OP_SLL   = 4'd4;
   localparam logic [3:0] OP_SRL   = 4'd5;
   localparam logic [3:0] OP_SNE   = 4'd6;
   localparam logic [3:0] OP_OVF   = 4'd7;
   localparam logic [3:0] OP_SUB   = 4'd8;
   localparam logic [3:0] OP_OR    = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;
   localparam logic [3:0] OP_DIVU  = 4'd12;
   localparam logic [3:0] OP_REMU  = 4'd13;
   localparam logic [3:0] OP_MULHU = 4'd14;
   localparam logic [3:0] OP_PASSB = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       op_q, op_nxt;
   logic [PW-1:0]    prod, prod_nxt;
   logic [PW-1:0]    mcand, mcand_nxt;
   logic [WIDTH-1:0] mplier, mplier_nxt;
   logic [WIDTH-1:0] quo, quo_nxt;
   logic [WIDTH-1:0] rem, rem_nxt;
   logic             in_ready_nxt, out_valid_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic             zero_nxt, carry_nxt, dz_nxt;

   // single-cycle datapath, evaluated on the live inputs at accept
   logic [WIDTH:0]   sum, dif;
   logic [SH_W-1:0]  shamt;
   logic             sh_big;
   logic [WIDTH-1:0] s_res;
   logic             s_carry;

   always_comb begin
      sum     = {1'b0, alu_input_a} + {1'b0, alu_input_b};
      dif     = {1'b0, alu_input_a} - {1'b0, alu_input_b};
      shamt   = alu_input_b[SH_W-1:0];
      sh_big  = (alu_input_b >= W_LIM);
      s_res   = '0;
      s_carry = 1'b0;
      case (alu_opcode)
         OP_AND:   s_res = alu_input_a & alu_input_b;
         OP_ADD:   begin s_res = sum[WIDTH-1:0]; s_carry = sum[WIDTH]; end
         OP_XOR:   s_res = alu_input_a ^ alu_input_b;
         OP_SLTU:  s_res = WIDTH'(alu_input_a < alu_input_b);
         OP_SLL:   s_res = sh_big ? '0 : (alu_input_a << shamt);
         OP_SRL:   s_res = sh_big ? '0 : (alu_input_a >> shamt);
         OP_SNE:   s_res = WIDTH'(alu_input_a != alu_input_b);
         OP_OVF:   begin s_res = WIDTH'(sum[WIDTH]); s_carry = sum[WIDTH]; end
         OP_SUB:   begin s_res = dif[WIDTH-1:0]; s_carry = dif[WIDTH]; end
         OP_OR:    s_res = alu_input_a | alu_input_b;
         OP_SRA:   s_res = sh_big ? {WIDTH{alu_input_a[WIDTH-1]}}
                                  : WIDTH'($unsigned($signed(alu_input_a) >>> shamt));
         OP_PASSB: s_res = alu_input_b;
         default:  s_res = '0;
      endcase
   end

   // iterative step values; mplier doubles as the divisor, mcand[WIDTH-1:0] keeps a for REMU
   logic             is_iter_in, op_is_div, last, mul_early, fin;
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_rem, div_quo, fin_res;
   logic [PW-1:0]    mul_acc;

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      op_nxt        = op_q;
      prod_nxt      = prod;
      mcand_nxt     = mcand;
      mplier_nxt    = mplier;
      quo_nxt       = quo;
      rem_nxt       = rem;
      out_valid_nxt = out_valid;
      res_nxt       = alu_out;
      zero_nxt      = zero;
      carry_nxt     = carry;
      dz_nxt        = div_zero;
      fin           = 1'b0;
      fin_res       = '0;

      is_iter_in = alu_opcode inside {OP_MUL, OP_DIVU, OP_REMU, OP_MULHU};
      op_is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
      last       = ((cnt + CNT_W'(1)) == CNT_LAST);
      div_sh     = {rem, quo[WIDTH-1]};
      div_ge     = (div_sh >= {1'b0, mplier});
      div_rem    = div_ge ? WIDTH'(div_sh - {1'b0, mplier}) : div_sh[WIDTH-1:0];
      div_quo    = {quo[WIDTH-2:0], div_ge};
      mul_acc    = mplier[0] ? (prod + mcand) : prod;
`ifdef SEQ_ALU_EARLY_TERM_EN
      mul_early  = (mplier[WIDTH-1:1] == '0);
`else
      mul_early  = 1'b0;
`endif

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_nxt = alu_opcode;
               if (is_iter_in) begin
                  state_nxt  = S_EXEC;
                  cnt_nxt    = '0;
                  prod_nxt   = '0;
                  mcand_nxt  = PW'(alu_input_a);
                  mplier_nxt = alu_input_b;
                  quo_nxt    = alu_input_a;
                  rem_nxt    = '0;
               end else begin
                  state_nxt     = S_DONE;
                  out_valid_nxt = 1'b1;
                  res_nxt       = s_res;
                  zero_nxt      = (s_res == '0);
                  carry_nxt     = s_carry;
                  dz_nxt        = 1'b0;
               end
            end
         end
         S_EXEC: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (op_is_div) begin
               rem_nxt = div_rem;
               quo_nxt = div_quo;
               fin     = last;
               if (op_q == OP_DIVU) fin_res = div_quo;
               else                 fin_res = (mplier == '0) ? mcand[WIDTH-1:0] : div_rem;
            end else begin
               prod_nxt   = mul_acc;
               mcand_nxt  = {mcand[PW-2:0], 1'b0};
               mplier_nxt = mplier >> 1;
               fin        = last || mul_early;
               fin_res    = (op_q == OP_MULHU) ? mul_acc[PW-1:WIDTH] : mul_acc[WIDTH-1:0];
            end
            if (fin) begin
               state_nxt     = S_DONE;
               out_valid_nxt = 1'b1;
               res_nxt       = fin_res;
               zero_nxt      = (fin_res == '0);
               carry_nxt     = 1'b0;
               dz_nxt        = op_is_div && (mplier == '0);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt     = S_IDLE;
               out_valid_nxt = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      in_ready_nxt = (state_nxt == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         op_q      <= '0;
         prod      <= '0;
         mcand     <= '0;
         mplier    <= '0;
         quo       <= '0;
         rem       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         alu_out   <= '0;
         zero      <= 1'b1;
         carry     <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         op_q      <= op_nxt;
         prod      <= prod_nxt;
         mcand     <= mcand_nxt;
         mplier    <= mplier_nxt;
         quo       <= quo_nxt;
         rem       <= rem_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         alu_out   <= res_nxt;
         zero      <= zero_nxt;
         carry     <= carry_nxt;
         div_zero  <= dz_nxt;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu (WIDTH=8) against an arithmetic model.
module tb_seq_alu;
   localparam int unsigned W   = 8;
   localparam int unsigned MOD = 1 << W;

   localparam logic [3:0] OP_AND = 4'd0,  OP_ADD = 4'd1,  OP_XOR = 4'd2,  OP_SLTU = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4,  OP_SRL = 4'd5,  OP_SNE = 4'd6,  OP_OVF  = 4'd7;
   localparam logic [3:0] OP_SUB = 4'd8,  OP_OR  = 4'd9,  OP_SRA = 4'd10, OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIVU = 4'd12, OP_REMU = 4'd13, OP_MULHU = 4'd14, OP_PASSB = 4'd15;

   logic         clk = 1'b0;
   logic         reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] alu_input_a, alu_input_b, alu_out;
   logic [3:0]   alu_opcode;
   logic         zero, carry, div_zero;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .alu_opcode(alu_opcode),
      .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
      .zero(zero), .carry(carry), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // reference model: plain integer arithmetic on the opcode definitions
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic dz);
      int unsigned ua, ub, full;
      int sa, q, d;
      ua = a; ub = b; full = ua + ub;
      r = '0; c = 1'b0; dz = 1'b0;
      case (op)
         OP_AND:   r = a & b;
         OP_ADD:   begin r = W'(full % MOD); c = (full >= MOD); end
         OP_XOR:   r = a ^ b;
         OP_SLTU:  r = (ua < ub) ? W'(1) : W'(0);
         OP_SLL:   r = (ub >= W) ? W'(0) : W'((ua * (32'd1 << ub)) % MOD);
         OP_SRL:   r = (ub >= W) ? W'(0) : W'(ua / (32'd1 << ub));
         OP_SNE:   r = (ua != ub) ? W'(1) : W'(0);
         OP_OVF:   begin r = (full >= MOD) ? W'(1) : W'(0); c = (full >= MOD); end
         OP_SUB:   begin r = W'((ua + MOD - ub) % MOD); c = (ua < ub); end
         OP_OR:    r = a | b;
         OP_SRA: begin
            sa = (ua >= MOD / 2) ? int'(ua) - int'(MOD) : int'(ua);
            if (ub >= W) r = (sa < 0) ? W'(MOD - 1) : W'(0);
            else begin
               d = 1 << ub;
               q = sa / d;
               if (sa < 0 && (sa % d) != 0) q = q - 1;
               r = W'(q);
            end
         end
         OP_MUL:   r = W'((ua * ub) % MOD);
         OP_MULHU: r = W'((ua * ub) / MOD);
         OP_DIVU:  if (ub == 0) begin r = W'(MOD - 1); dz = 1'b1; end else r = W'(ua / ub);
         OP_REMU:  if (ub == 0) begin r = a; dz = 1'b1; end else r = W'(ua % ub);
         default:  r = b;
      endcase
   endfunction

   // cycles from the accepting cycle to the first cycle with out_valid
   function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
      if (op == OP_MUL || op == OP_MULHU) begin
`ifdef SEQ_ALU_EARLY_TERM_EN
         return 1 + ((b == 0) ? 1 : $clog2(int'(b) + 1));
`else
         return 1 + W;
`endif
      end
      if (op == OP_DIVU || op == OP_REMU) return 1 + W;
      return 1;
   endfunction

   // issue one op at a negedge, scramble inputs after accept, wait for out_valid (bounded)
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic c, output logic dz,
                         output int lat, output bit busy_ok);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
      in_valid = 1'b1; alu_opcode = op; alu_input_a = a; alu_input_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0; alu_opcode = 4'($urandom); alu_input_a = W'($urandom); alu_input_b = W'($urandom);
      lat = 0; busy_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid && in_ready) busy_ok = 1'b0;
      end while (!out_valid && lat < 100);
      r = alu_out; z = zero; c = carry; dz = div_zero;
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [W-1:0] r; logic z, c, dz; int lat; bit busy;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (alu_out !== 8'h00)  begin errors++; $display("FAIL rst_alu_out got %h exp 00", alu_out); end
      checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL rst_zero got %b exp 1", zero); end
      checks++; if (carry !== 1'b0 || div_zero !== 1'b0) begin
         errors++; $display("FAIL rst_flags got carry=%b dz=%b exp 0 0", carry, div_zero); end
      // async reset while a multiply is iterating
      @(negedge clk);
      in_valid = 1'b1; alu_opcode = OP_MUL; alu_input_a = 8'h37; alu_input_b = 8'hC9;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_exec_in_ready got %b exp 0", in_ready); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL async_rst_hs got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
      checks++; if (alu_out !== 8'h00 || zero !== 1'b1) begin
         errors++; $display("FAIL async_rst_out got alu_out=%h zero=%b exp 00 1", alu_out, zero); end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);
      run_op(OP_ADD, 8'd3, 8'd4, r, z, c, dz, lat, busy);
      checks++; if (r !== 8'd7) begin errors++; $display("FAIL post_rst_add got %h exp 07", r); end
      checks++; if (lat !== 1)  begin errors++; $display("FAIL post_rst_add_lat got %0d exp 1", lat); end
      retire();
   endtask

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a, b, r;
      logic         c, dz;
   } vec_t;

   task automatic test_directed();
      vec_t tbl[20];
      logic [W-1:0] r; logic z, c, dz; int lat; bit busy;
      tbl = '{
         '{OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 1'b0},
         '{OP_OVF,   8'hFF, 8'h01, 8'h01, 1'b1, 1'b0},
         '{OP_SUB,   8'h02, 8'h05, 8'hFD, 1'b1, 1'b0},
         '{OP_MUL,   8'h13, 8'h0B, 8'hD1, 1'b0, 1'b0},
         '{OP_MULHU, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0},
         '{OP_DIVU,  8'd200, 8'd7, 8'd28, 1'b0, 1'b0},
         '{OP_REMU,  8'd200, 8'd7, 8'd4,  1'b0, 1'b0},
         '{OP_DIVU,  8'd9,  8'd0,  8'hFF, 1'b0, 1'b1},
         '{OP_REMU,  8'd9,  8'd0,  8'd9,  1'b0, 1'b1},
         '{OP_SLL,   8'h81, 8'd1,  8'h02, 1'b0, 1'b0},
         '{OP_SRL,   8'h81, 8'd8,  8'h00, 1'b0, 1'b0},
         '{OP_SRA,   8'h80, 8'd9,  8'hFF, 1'b0, 1'b0},
         '{OP_MUL,   8'h55, 8'h03, 8'hFF, 1'b0, 1'b0},
         '{OP_MUL,   8'h55, 8'h00, 8'h00, 1'b0, 1'b0},
         '{OP_SLTU,  8'h03, 8'h05, 8'h01, 1'b0, 1'b0},
         '{OP_SNE,   8'h05, 8'h05, 8'h00, 1'b0, 1'b0},
         '{OP_PASSB, 8'h00, 8'hA5, 8'hA5, 1'b0, 1'b0},
         '{OP_AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0},
         '{OP_XOR,   8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0},
         '{OP_OR,    8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0}
      };
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, c, dz, lat, busy);
         checks++; if (r !== tbl[i].r) begin
            errors++; $display("FAIL dir%0d_result op=%0d got %h exp %h", i, tbl[i].op, r, tbl[i].r); end
         checks++; if (z !== (tbl[i].r == 0)) begin
            errors++; $display("FAIL dir%0d_zero got %b exp %b", i, z, (tbl[i].r == 0)); end
         checks++; if (c !== tbl[i].c || dz !== tbl[i].dz) begin
            errors++; $display("FAIL dir%0d_flags got c=%b dz=%b exp %b %b", i, c, dz, tbl[i].c, tbl[i].dz); end
         checks++; if (lat !== exp_lat(tbl[i].op, tbl[i].b)) begin
            errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, exp_lat(tbl[i].op, tbl[i].b)); end
         checks++; if (!busy) begin errors++; $display("FAIL dir%0d_busy got in_ready=1 exp 0 while executing", i); end
         retire();
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] r; logic z, c, dz; int lat; bit busy;
      run_op(OP_ADD, 8'h10, 8'h20, r, z, c, dz, lat, busy);
      checks++; if (r !== 8'h30) begin errors++; $display("FAIL hold_first got %h exp 30", r); end
      in_valid = 1'b1; alu_opcode = OP_XOR; alu_input_a = 8'h0F; alu_input_b = 8'hF0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++; if (alu_out !== 8'h30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_stable%0d got out=%h v=%b rdy=%b exp 30 1 0", k, alu_out, out_valid, in_ready); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL hold_bubble got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || alu_out !== 8'hFF) begin
         errors++; $display("FAIL hold_next got v=%b out=%h exp 1 ff", out_valid, alu_out); end
      retire();
   endtask

   task automatic test_random();
      logic [3:0] op; logic [W-1:0] a, b, r, er; logic z, c, dz, ec, edz; int lat; bit busy;
      for (int n = 0; n < 150; n++) begin
         op = 4'($urandom); a = W'($urandom); b = W'($urandom);
         if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 10));
         if ((op == OP_DIVU || op == OP_REMU) && $urandom_range(0, 4) == 0) b = '0;
         if ((op == OP_MUL || op == OP_MULHU) && $urandom_range(0, 2) == 0) b = W'($urandom_range(0, 7));
         model(op, a, b, er, ec, edz);
         run_op(op, a, b, r, z, c, dz, lat, busy);
         checks++; if (r !== er || z !== (er == 0)) begin
            errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h z=%b exp %h", n, op, a, b, r, z, er); end
         checks++; if (c !== ec || dz !== edz) begin
            errors++; $display("FAIL rnd%0d_flags op=%0d got c=%b dz=%b exp %b %b", n, op, c, dz, ec, edz); end
         checks++; if (lat !== exp_lat(op, b) || !busy) begin
            errors++; $display("FAIL rnd%0d_timing op=%0d got lat=%0d busy=%b exp %0d 1", n, op, lat, busy, exp_lat(op, b)); end
         retire();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_retire got %b exp 0", n, out_valid); end
      end
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_input_a = '0; alu_input_b = '0; alu_opcode = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_directed();
      test_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
